// File: rtl/data_memory_unit.sv
// Word-addressed data memory stage with fixed wait states and a stall handshake toward the datapath.
// Optional `DMEM_STATS_EN adds saturating counters of error-free loads and stores.
module data_memory_unit #(
    parameter int          MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
    parameter int          WAIT_CYCLES  = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        error_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_count_o,
    output logic [15:0] store_count_o
`endif
);

    localparam int AW = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        is_write_reg;
    logic [31:0] read_data_reg;
    logic [31:0] mem [MEMORY_DEPTH];

    logic        request;
    logic [31:0] eff_addr;
    logic        eff_write;
    logic [31:0] offset;
    logic        addr_err;
    logic [AW-1:0] mem_index;
    logic        enter_done;

    assign request = mem_read_i | mem_write_i;

    // With a single wait state DONE is entered straight from IDLE, before the
    // capture registers hold the request, so decode the live inputs there.
    assign eff_addr  = (state_reg == S_IDLE) ? address_i   : addr_reg;
    assign eff_write = (state_reg == S_IDLE) ? mem_write_i : is_write_reg;
    assign offset    = eff_addr - BASE_ADDRESS;
    assign addr_err  = (offset[1:0] != 2'b00) ||
                       ({2'b00, offset[31:2]} >= 32'(MEMORY_DEPTH));
    assign mem_index = offset[AW+1:2];
    assign enter_done = (state_next == S_DONE) && (state_reg != S_DONE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (request) begin
                    cnt_next   = 4'(WAIT_CYCLES - 1);
                    state_next = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        error_o = 1'b0;
        case (state_reg)
            S_IDLE:  stall_o = request;
            S_WAIT:  stall_o = 1'b1;
            S_DONE:  error_o = addr_err;
            default: stall_o = 1'b0;
        endcase
    end

    // Request fields are latched once; later input changes are ignored.
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_reg == S_IDLE && request) begin
            addr_reg     <= address_i;
            wdata_reg    <= write_data_i;
            is_write_reg <= mem_write_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            read_data_reg <= 32'd0;
        else if (enter_done && !eff_write)
            read_data_reg <= addr_err ? 32'd0 : mem[mem_index];
    end

    assign read_data_o = read_data_reg;

    // Store commits on the edge leaving DONE; a reset there discards it.
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_reg == S_DONE && is_write_reg && !addr_err)
            mem[mem_index] <= wdata_reg;
    end

`ifdef DMEM_STATS_EN
    logic [15:0] load_count_reg;
    logic [15:0] store_count_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            load_count_reg  <= 16'd0;
            store_count_reg <= 16'd0;
        end else if (state_reg == S_DONE && !addr_err) begin
            if (is_write_reg && store_count_reg != 16'hFFFF)
                store_count_reg <= store_count_reg + 16'd1;
            if (!is_write_reg && load_count_reg != 16'hFFFF)
                load_count_reg <= load_count_reg + 16'd1;
        end
    end

    assign load_count_o  = load_count_reg;
    assign store_count_o = store_count_reg;
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: main checks on a 2-wait-state instance,
// latency sweep on 1- and 15-wait-state instances sharing the same inputs.
module tb_data_memory_unit;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] LAST = 32'h1001_0000 + 32'd252;
    localparam logic [31:0] OOR  = 32'h1001_0000 + 32'd256;

    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [31:0] rd2, rd1, rd15;
    logic        st2, st1, st15, er2, er1, er15;
`ifdef DMEM_STATS_EN
    logic [15:0] lc2, sc2, lc1, sc1, lc15, sc15;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_memory_unit #(.MEMORY_DEPTH(64), .BASE_ADDRESS(BASE), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .reset_i(reset), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .address_i(address), .write_data_i(write_data),
        .read_data_o(rd2), .stall_o(st2), .error_o(er2)
`ifdef DMEM_STATS_EN
        , .load_count_o(lc2), .store_count_o(sc2)
`endif
    );

    data_memory_unit #(.MEMORY_DEPTH(64), .BASE_ADDRESS(BASE), .WAIT_CYCLES(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .address_i(address), .write_data_i(write_data),
        .read_data_o(rd1), .stall_o(st1), .error_o(er1)
`ifdef DMEM_STATS_EN
        , .load_count_o(lc1), .store_count_o(sc1)
`endif
    );

    data_memory_unit #(.MEMORY_DEPTH(64), .BASE_ADDRESS(BASE), .WAIT_CYCLES(15)) dut15 (
        .clk_i(clk), .reset_i(reset), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .address_i(address), .write_data_i(write_data),
        .read_data_o(rd15), .stall_o(st15), .error_o(er15)
`ifdef DMEM_STATS_EN
        , .load_count_o(lc15), .store_count_o(sc15)
`endif
    );

    // Drives one request on the 2-wait instance, holding it while stalled;
    // a2 and ~d replace the address/data after the first cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] a2, input logic [31:0] d,
                          output int stalls, output logic err_done,
                          output logic err_after, output logic [31:0] rd_done);
        bit done;
        done = 0; stalls = 0; err_done = 0; err_after = 0; rd_done = 32'd0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; address = a; write_data = d;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (st2) begin
                stalls++;
                @(posedge clk); #1;
                address = a2; write_data = ~d;
            end else begin
                done = 1; err_done = er2; rd_done = rd2;
            end
        end
        if (!done) stalls = -1;
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        @(negedge clk);
        err_after = er2;
        $display("[TB] access rd=%0b wr=%0b addr=%h stalls=%0d err=%0b data=%h",
                 rd, wr, a, stalls, err_done, rd_done);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset = 1;
        @(posedge clk); #1; reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; mem_read = 0; mem_write = 0; address = 0; write_data = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        tests++; if (rd2 !== 32'd0) begin fails++; $display("FAIL reset_rd2: got %h want 0", rd2); end
        tests++; if (st2 !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", st2); end
        tests++; if (er2 !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", er2); end
        tests++; if (rd1 !== 32'd0 || rd15 !== 32'd0) begin fails++; $display("FAIL reset_rd_other: got %h/%h want 0", rd1, rd15); end
    endtask

    task automatic test_store_load();
        int s; logic e, ea; logic [31:0] r;
        access(0, 1, BASE + 8, BASE + 8, 32'hDEAD_BEEF, s, e, ea, r);
        tests++; if (s !== 2) begin fails++; $display("FAIL sw_stall: got %0d want 2", s); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL sw_error: got %b want 0", e); end
        access(1, 0, BASE + 8, BASE + 8, 32'd0, s, e, ea, r);
        tests++; if (s !== 2) begin fails++; $display("FAIL lw_stall: got %0d want 2", s); end
        tests++; if (r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_data: got %h want deadbeef", r); end
        tests++; if (rd2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_hold: got %h want deadbeef", rd2); end
    endtask

    task automatic test_errors();
        int s; logic e, ea; logic [31:0] r;
        access(0, 1, BASE, BASE, 32'h1111_1111, s, e, ea, r);
        access(0, 1, LAST, LAST, 32'h2222_2222, s, e, ea, r);
        access(1, 0, BASE + 2, BASE + 2, 32'd0, s, e, ea, r);
        tests++; if (e !== 1'b1 || ea !== 1'b0) begin fails++; $display("FAIL lw_misalign_err: got %b%b want 10", e, ea); end
        tests++; if (r !== 32'd0) begin fails++; $display("FAIL lw_misalign_data: got %h want 0", r); end
        tests++; if (s !== 2) begin fails++; $display("FAIL lw_misalign_stall: got %0d want 2", s); end
        access(1, 0, LAST, LAST, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'h2222_2222 || e !== 1'b0) begin fails++; $display("FAIL lw_last: got %h err %b want 22222222", r, e); end
        access(1, 0, OOR, OOR, 32'd0, s, e, ea, r);
        tests++; if (e !== 1'b1 || ea !== 1'b0) begin fails++; $display("FAIL lw_range_err: got %b%b want 10", e, ea); end
        tests++; if (r !== 32'd0) begin fails++; $display("FAIL lw_range_data: got %h want 0", r); end
        access(0, 1, BASE + 2, BASE + 2, 32'h0000_BAD0, s, e, ea, r);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL sw_misalign_err: got %b want 1", e); end
        access(0, 1, OOR, OOR, 32'h0000_BAD1, s, e, ea, r);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL sw_range_err: got %b want 1", e); end
        access(1, 0, BASE, BASE, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'h1111_1111) begin fails++; $display("FAIL word0_kept: got %h want 11111111", r); end
        access(1, 0, LAST, LAST, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'h2222_2222) begin fails++; $display("FAIL last_kept: got %h want 22222222", r); end
    endtask

    task automatic test_reset_mid_access();
        int s; logic e, ea; logic [31:0] r;
        @(posedge clk); #1;
        mem_write = 1; address = BASE; write_data = 32'h1234_5678;
        @(posedge clk); #1;
        mem_write = 0;
        @(negedge clk);
        tests++; if (st2 !== 1'b1) begin fails++; $display("FAIL mid_wait_stall: got %b want 1", st2); end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        tests++; if (st2 !== 1'b0 || er2 !== 1'b0) begin fails++; $display("FAIL mid_reset_idle: got stall %b err %b want 0 0", st2, er2); end
        tests++; if (rd2 !== 32'd0) begin fails++; $display("FAIL mid_reset_rd: got %h want 0", rd2); end
        $display("[TB] reset during store wait: stall=%b", st2);
        access(1, 0, BASE, BASE, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'h1111_1111) begin fails++; $display("FAIL mid_reset_discard: got %h want 11111111", r); end
    endtask

    task automatic test_capture();
        int s; logic e, ea; logic [31:0] r;
        access(0, 1, BASE + 32'h14, BASE + 32'h14, 32'h5555_5555, s, e, ea, r);
        access(0, 1, BASE + 32'h10, BASE + 32'h14, 32'hCAFE_0001, s, e, ea, r);
        access(1, 0, BASE + 32'h14, BASE + 32'h14, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'h5555_5555) begin fails++; $display("FAIL capture_other_word: got %h want 55555555", r); end
        access(1, 0, BASE + 32'h10, BASE + 32'h14, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'hCAFE_0001) begin fails++; $display("FAIL capture_addr_data: got %h want cafe0001", r); end
    endtask

    task automatic test_conflict();
        int s; logic e, ea; logic [31:0] r;
        access(1, 1, BASE + 32'h18, BASE + 32'h18, 32'h0BAD_F00D, s, e, ea, r);
        tests++; if (r !== 32'hCAFE_0001 || e !== 1'b0) begin fails++; $display("FAIL conflict_rd_held: got %h err %b want cafe0001", r, e); end
        access(1, 0, BASE + 32'h18, BASE + 32'h18, 32'd0, s, e, ea, r);
        tests++; if (r !== 32'h0BAD_F00D) begin fails++; $display("FAIL conflict_written: got %h want 0badf00d", r); end
    endtask

    task automatic test_latency_sweep();
        int s1, s15, last1, last15;
        logic [31:0] r1, r15, r15_early;
        s1 = 0; s15 = 0; last1 = -1; last15 = -1; r1 = 0; r15 = 0; r15_early = 0;
        pulse_reset();
        @(posedge clk); #1;
        mem_write = 1; address = BASE + 32'h20; write_data = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        mem_write = 0;
        repeat (20) @(posedge clk);
        #1 mem_read = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (st1) begin s1++; last1 = c; end
            if (st15) begin s15++; last15 = c; end
            if (c == 1) r1 = rd1;
            if (c == 14) r15_early = rd15;
            if (c == 15) r15 = rd15;
            @(posedge clk); #1;
            mem_read = 0;
        end
        $display("[TB] sweep: w1 stalls=%0d last=%0d, w15 stalls=%0d last=%0d", s1, last1, s15, last15);
        tests++; if (s1 !== 1 || last1 !== 0) begin fails++; $display("FAIL sweep_w1_stall: got %0d last %0d want 1 last 0", s1, last1); end
        tests++; if (s15 !== 15 || last15 !== 14) begin fails++; $display("FAIL sweep_w15_stall: got %0d last %0d want 15 last 14", s15, last15); end
        tests++; if (r1 !== 32'hA5A5_0F0F) begin fails++; $display("FAIL sweep_w1_data: got %h want a5a50f0f", r1); end
        tests++; if (r15_early !== 32'd0) begin fails++; $display("FAIL sweep_w15_early: got %h want 0", r15_early); end
        tests++; if (r15 !== 32'hA5A5_0F0F) begin fails++; $display("FAIL sweep_w15_data: got %h want a5a50f0f", r15); end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        int s; logic e, ea; logic [31:0] r;
        pulse_reset();
        for (int i = 0; i < 3; i++) access(1, 0, BASE + 8, BASE + 8, 32'd0, s, e, ea, r);
        for (int i = 0; i < 2; i++) access(0, 1, BASE + 32'h24, BASE + 32'h24, 32'h77, s, e, ea, r);
        access(1, 0, BASE + 1, BASE + 1, 32'd0, s, e, ea, r);
        tests++; if (lc2 !== 16'd3) begin fails++; $display("FAIL stats_loads: got %0d want 3", lc2); end
        tests++; if (sc2 !== 16'd2) begin fails++; $display("FAIL stats_stores: got %0d want 2", sc2); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_reset_mid_access();
        test_capture();
        test_conflict();
        test_latency_sweep();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Word-addressed data memory stage sitting directly downstream of the ALU: it consumes the ALU result as the effective address of `lw`/`sw`, performs the access after a fixed number of wait states, and returns load data toward the register-file write-back mux. While an access is in flight it asserts a stall to freeze the PC and register-file writes of the single-cycle datapath.

## Interface
- `MEMORY_DEPTH`, 64: number of 32-bit words (power of two, 4..1024).
- `BASE_ADDRESS`, 32'h1001_0000: byte address mapped to word 0.
- `WAIT_CYCLES`, 2: stall cycles per access, legal range 1..15.

Ports:
- `clk_i` input 1: clock, all state updates on its rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `mem_read_i` input 1: load request (from control unit).
- `mem_write_i` input 1: store request.
- `address_i` input 32: byte address, driven by ALU `alu_data_o`.
- `write_data_i` input 32: store data (register-file rt read port).
- `read_data_o` output 32: load data, registered.
- `stall_o` output 1: access in progress; CPU holds PC and request.
- `error_o` output 1: one-cycle pulse, access misaligned or out of range.

## Operation
- States: IDLE, WAIT, DONE. 2-bit state, 4-bit down-counter `cnt`.
- Request = `mem_read_i | mem_write_i`; both high → treated as write.
- IDLE, request high: capture address, write data, op into internal registers; `stall_o`=1 (combinational from request); `cnt`←WAIT_CYCLES−1; next = DONE if WAIT_CYCLES==1 else WAIT.
- IDLE, no request: `stall_o`=0, stay.
- WAIT: `stall_o`=1; `cnt`←`cnt`−1; next = DONE when `cnt`==1.
- DONE: `stall_o`=0; next = IDLE. Read path: `read_data_o` loaded on the edge entering DONE. Write path: memory written on the edge leaving DONE.
- Inputs after capture are ignored; dropping the request mid-access does not abort it.
- Address decode: offset = captured address − BASE_ADDRESS (32-bit unsigned, wrap allowed); index = offset[31:2].
- Error: offset[1:0]≠0 or index ≥ MEMORY_DEPTH. On error: no write, `read_data_o`←0, `error_o`=1 during DONE only. Latency unchanged.
- Memory array is not reset; contents undefined until written.
- `read_data_o` holds its value until the next completed load.

## Timing
- Request seen in cycle 0 → `stall_o` high cycles 0..WAIT_CYCLES−1, DONE in cycle WAIT_CYCLES.
- Load data valid in DONE cycle and after; store visible to a load starting the cycle after DONE.
- Back-to-back: request present in the cycle after DONE (IDLE) starts a new access immediately; no bubble beyond IDLE.
- Reset values: state IDLE, `cnt` 0, `read_data_o` 0, `error_o` 0, `stall_o` 0 (in IDLE with no request).
- Reset in any state: returns to IDLE next cycle; pending store discarded; memory contents retained.
- Reset has priority over request in the same cycle.

## Configuration
- `DMEM_STATS_EN` defined: adds outputs `load_count_o` (16) and `store_count_o` (16). Each increments in DONE for an error-free load/store, saturates at 16'hFFFF, cleared by `reset_i`.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Store/load: WAIT_CYCLES=2, `sw` 32'hDEAD_BEEF at 32'h1001_0008, then `lw` same address → `stall_o` high 2 cycles each, `read_data_o`=32'hDEAD_BEEF in the load's DONE cycle.
- Latency sweep: WAIT_CYCLES=1 and 15 → `stall_o` high exactly 1 and 15 cycles per request, DONE one cycle after last stall cycle.
- Errors: `lw` at 32'h1001_0002 and at BASE+4·MEMORY_DEPTH → `error_o` one-cycle pulse, `read_data_o`=0; `sw` at those addresses leaves word 0 and last word unchanged.
- Reset mid-access: `sw` 32'h1234_5678 at 32'h1001_0000, assert `reset_i` in second WAIT cycle → `stall_o` 0 next cycle, subsequent load returns prior contents (not 32'h1234_5678).
- Capture and conflict: change `address_i` during WAIT → original address used; `mem_read_i`=`mem_write_i`=1 → write performed, `read_data_o` unchanged.
- Stats (with `DMEM_STATS_EN`): 3 good loads, 2 good stores, 1 misaligned load → `load_count_o`=3, `store_count_o`=2.
